// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared constants for the register-file write-back arbiter: default
// requester count and data width, the register address width, and the fixed
// requester slot assignments.
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 32;
  localparam int AW       = 5;

  // Requester slot assignments on the req/req_addr/req_data buses
  localparam int REQ_ALU  = 0;
  localparam int REQ_DM   = 1;
  localparam int REQ_CP0  = 2;
  localparam int REQ_LINK = 3;

endpackage

// File: rtl/rf_wb_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. It searches upward from ptr+1 (modulo
// NREQ) and returns the first requesting index as a one-hot vector.
//   req  : request vector
//   ptr  : index granted most recently
//   gnt  : one-hot selection, all-zero when req is zero
// ---------------------------------------------------------------------------
module rr_pick
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic [PW-1:0] idx;

  // Scan from the farthest offset down to the nearest one, so the last match
  // written is the requester closest to ptr+1.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
// Arbitrates NREQ write-back requesters onto the single register-file write
// port, with a one-cycle registered write, and flags read operands that have
// a write requested or in flight.
//   clk, reset          : clock, asynchronous active-high reset
//   req                 : per-requester write request
//   req_addr, req_data  : per-requester destination register and data
//   wb_stall            : write port unavailable, blocks new grants
//   gnt                 : one-hot grant (combinational)
//   wb_we/addr/data     : registered write to the register file
//   rs, rt              : read addresses being decoded
//   rs/rt_pending       : a write to rs/rt is requested or in flight
// ---------------------------------------------------------------------------
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [DW*NREQ-1:0] req_data,
  input  logic               wb_stall,
  output logic [NREQ-1:0]    gnt,
  output logic               wb_we,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      wb_data,
  input  logic [AW-1:0]      rs,
  input  logic [AW-1:0]      rt,
  output logic               rs_pending,
  output logic               rt_pending
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] pick;
  logic            gnt_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            rs_req_hit;
  logic            rt_req_hit;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick)
  );

  assign gnt     = (reset || wb_stall) ? '0 : pick;
  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx  = PW'(i);
        sel_addr = req_addr[AW*i +: AW];
        sel_data = req_data[DW*i +: DW];
      end
    end
  end

  // A grant to r0 is consumed (ptr advances, address/data load) but never
  // produces a write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr     <= PW'(NREQ - 1);
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= gnt_any && (sel_addr != '0);
      if (gnt_any) begin
        ptr     <= gnt_idx;
        wb_addr <= sel_addr;
        wb_data <= sel_data;
      end
    end
  end

  always_comb begin
    rs_req_hit = 1'b0;
    rt_req_hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (req_addr[AW*i +: AW] == rs)) rs_req_hit = 1'b1;
      if (req[i] && (req_addr[AW*i +: AW] == rt)) rt_req_hit = 1'b1;
    end
  end

  assign rs_pending = (rs != '0) && (rs_req_hit || (wb_we && (wb_addr == rs)));
  assign rt_pending = (rt != '0) && (rt_req_hit || (wb_we && (wb_addr == rt)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Directed bench for rf_wb_arbiter. Stimulus pushes expected grants and
// expected register writes into queues; a monitor pops and compares them
// whenever the DUT shows a grant or a write strobe.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic               wb_stall;
  logic [NREQ-1:0]    gnt;
  logic               wb_we;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic [AW-1:0]      rs;
  logic [AW-1:0]      rt;
  logic               rs_pending;
  logic               rt_pending;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  logic [NREQ-1:0]    gnt_q [$];
  logic [AW+DW-1:0]   wb_q  [$];
  logic [DW-1:0]      rf_model [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[AW*i +: AW] = a[i];
      req_data[DW*i +: DW] = d[i];
    end
  end

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .wb_stall   (wb_stall),
    .gnt        (gnt),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rs         (rs),
    .rt         (rt),
    .rs_pending (rs_pending),
    .rt_pending (rt_pending)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req      = '0;
    wb_stall = 1'b0;
    rs       = '0;
    rt       = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_inputs();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic exp_wr(input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    wb_q.push_back({ad, dt});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'd0);
        else                   chk("gnt", 64'(gnt), 64'(gnt_q.pop_front()));
      end
      if (wb_we) begin
        if (wb_q.size() == 0) chk("wb_unexpected", 64'({wb_addr, wb_data}), 64'd0);
        else                  chk("wb_write", 64'({wb_addr, wb_data}), 64'(wb_q.pop_front()));
        rf_model[wb_addr] = wb_data;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    reset = 1'b1;
    clr_inputs();
    req  = 4'b1111;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3; a[3] = 5'd4;
    mid();
    chk("reset_we",   64'(wb_we),   64'd0);
    chk("reset_addr", 64'(wb_addr), 64'd0);
    chk("reset_data", 64'(wb_data), 64'd0);
    chk("reset_gnt",  64'(gnt),     64'd0);
    tick();
    reset = 1'b0;
    clr_inputs();
    tick();

    // Two requesters, slots 0 and 2
    a[0] = 5'd5; d[0] = 32'h11;
    a[2] = 5'd6; d[2] = 32'h22;
    rs   = 5'd6;
    req  = 4'b0101;
    gnt_q.push_back(4'b0001); exp_wr(5'd5, 32'h11);
    mid();
    chk("t032_rs_pending", 64'(rs_pending), 64'd1);
    tick();
    req = 4'b0100;
    gnt_q.push_back(4'b0100); exp_wr(5'd6, 32'h22);
    tick();
    req = 4'b0000;
    repeat (2) tick();

    // All four requesting continuously
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 5'(10 + i);
      d[i] = 32'(32'h100 + i);
    end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      gnt_q.push_back(4'(1 << (k % 4)));
      exp_wr(5'(10 + (k % 4)), 32'(32'h100 + (k % 4)));
      mid();
      if (k > 0) chk("t033_we", 64'(wb_we), 64'd1);
      tick();
    end
    req = 4'b0000;
    repeat (2) tick();

    // Grant to r0 is consumed without a write
    do_reset();
    a[1] = 5'd0; d[1] = 32'hFFFF;
    req  = 4'b0010;
    gnt_q.push_back(4'b0010);
    mid();
    chk("t034_rs0_pending", 64'(rs_pending), 64'd0);
    tick();
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 5'(20 + i);
      d[i] = 32'(200 + i);
    end
    req = 4'b1111;
    gnt_q.push_back(4'b0100); exp_wr(5'd22, 32'd202);
    mid();
    chk("t034_we0", 64'(wb_we), 64'd0);
    tick();
    req = 4'b0000;
    repeat (2) tick();

    // Stall blocks grants but not an already registered write
    do_reset();
    a[0] = 5'd3; d[0] = 32'h33;
    req  = 4'b0001;
    gnt_q.push_back(4'b0001); exp_wr(5'd3, 32'h33);
    tick();
    a[1]     = 5'd7; d[1] = 32'h77;
    req      = 4'b0010;
    wb_stall = 1'b1;
    rs       = 5'd7;
    mid();
    chk("t035_we_in_stall", 64'(wb_we), 64'd1);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) mid();
      chk("t035_gnt_stalled", 64'(gnt),        64'd0);
      chk("t035_rs_pending",  64'(rs_pending), 64'd1);
      tick();
    end
    wb_stall = 1'b0;
    gnt_q.push_back(4'b0010); exp_wr(5'd7, 32'h77);
    mid();
    chk("t035_rs_pending_gnt", 64'(rs_pending), 64'd1);
    tick();
    req = 4'b0000;
    mid();
    chk("t035_rs_pending_wb", 64'(rs_pending), 64'd1);
    tick();
    mid();
    chk("t035_rs_pending_clr", 64'(rs_pending), 64'd0);
    tick();

    // Reset right after a grant discards the write
    do_reset();
    a[2] = 5'd9; d[2] = 32'h99;
    req  = 4'b0100;
    gnt_q.push_back(4'b0100);
    mid();
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 4'b0000;
    #1;
    chk("t036_we_reset", 64'(wb_we), 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 5'(24 + i);
      d[i] = 32'(240 + i);
    end
    req = 4'b1111;
    gnt_q.push_back(4'b0001); exp_wr(5'd24, 32'd240);
    tick();
    req = 4'b0000;
    repeat (2) tick();
    chk("t036_r9_unwritten", 64'(rf_model[9]), 64'd0);

    // Same destination from two slots: later grant wins
    do_reset();
    a[0] = 5'd31; d[0] = 32'hA;
    a[3] = 5'd31; d[3] = 32'hB;
    rt   = 5'd31;
    req  = 4'b1001;
    gnt_q.push_back(4'b0001); exp_wr(5'd31, 32'hA);
    mid();
    chk("t037_rt_pending_1", 64'(rt_pending), 64'd1);
    tick();
    req = 4'b1000;
    gnt_q.push_back(4'b1000); exp_wr(5'd31, 32'hB);
    mid();
    chk("t037_rt_pending_2", 64'(rt_pending), 64'd1);
    tick();
    req = 4'b0000;
    mid();
    chk("t037_rt_pending_3", 64'(rt_pending), 64'd1);
    tick();
    mid();
    chk("t037_rt_pending_clr", 64'(rt_pending), 64'd0);
    chk("t037_r31_final",      64'(rf_model[31]), 64'hB);
    tick();

    repeat (2) tick();
    chk("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
    chk("wb_queue_empty",  64'(wb_q.size()),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write-back requesters.
REQ-002 Parameter DW, default 32, data width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  NREQ  per-requester write request, held high until granted.
REQ-006 req_addr  input  5*NREQ  destination register per requester, slice i = bits [5i+4:5i].
REQ-007 req_data  input  DW*NREQ  write data per requester, slice i = bits [DW*i+DW-1:DW*i].
REQ-008 wb_stall  input  1  write port unavailable this cycle.
REQ-009 gnt  output  NREQ  one-hot grant, combinational, same cycle as selection.
REQ-010 wb_we  output  1  registered write enable to register file.
REQ-011 wb_addr  output  5  registered write address.
REQ-012 wb_data  output  DW  registered write data.
REQ-013 rs, rt  input  5 each  read addresses being decoded.
REQ-014 rs_pending, rt_pending  output  1 each  a write to rs/rt is requested or in flight.

Function
REQ-015 gnt SHALL be all-zero when wb_stall=1 or req=0.
REQ-016 Otherwise gnt SHALL select exactly one requesting index, round-robin, searching upward from ptr+1 modulo NREQ.
REQ-017 ptr SHALL update to the granted index on each grant cycle; unchanged otherwise.
REQ-018 On a grant to i, the next edge SHALL load wb_addr=req_addr[i], wb_data=req_data[i], wb_we=1 (latency 1 cycle).
REQ-019 A grant whose req_addr is 0 SHALL be consumed (gnt asserted, ptr updated) but SHALL produce wb_we=0.
REQ-020 With no grant in a cycle, wb_we SHALL be 0 next cycle; wb_addr/wb_data SHALL hold.
REQ-021 A requester observing gnt[i]=1 SHALL drop req[i] or present a new write next cycle; a held req SHALL be treated as a new request.
REQ-022 Two requesters targeting the same register SHALL both be written, in grant order; the later grant wins in the register file.
REQ-023 wb_stall=1 SHALL not clear an already registered wb_we for the current cycle; it SHALL only block new grants.
REQ-024 rs_pending SHALL be 1 iff rs!=0 and (any req[i] with req_addr[i]==rs, or wb_we=1 with wb_addr==rs); rt_pending likewise; purely combinational.
REQ-025 With all NREQ requesting continuously and wb_stall=0, each SHALL be granted once every NREQ cycles (no starvation).

Reset
REQ-026 reset SHALL asynchronously force wb_we=0, wb_addr=0, wb_data=0, ptr=NREQ-1 (so index 0 has first priority).
REQ-027 An in-flight registered write SHALL be discarded by reset; gnt SHALL be 0 while reset is high.
REQ-028 After reset release, first grant SHALL occur on the first edge with req!=0 and wb_stall=0.

Structure
REQ-029 Shared package SHALL hold NREQ default, DW default, and requester indices REQ_ALU=0, REQ_DM=1, REQ_CP0=2, REQ_LINK=3.
REQ-030 Round-robin selection SHALL be a sub-module rr_pick (inputs req, ptr; output one-hot gnt), purely combinational.
REQ-031 The top SHALL contain only ptr, output registers and pending-compare logic.

Verification
REQ-032 After reset, req=4'b0101, addrs 5/6 (slots 0/2), data 0x11/0x22 held -> gnt 0001 then 0100; wb writes r5=0x11 then r6=0x22 on following edges.
REQ-033 req=4'b1111 held 8 cycles -> grant order 0,1,2,3,0,1,2,3; wb_we=1 every cycle after first.
REQ-034 req[1] with addr 0, data 0xFFFF -> gnt=0010 for one cycle, wb_we stays 0, ptr=1.
REQ-035 wb_stall=1 for 3 cycles with req=4'b0010 -> gnt=0 throughout; grant on first cycle stall drops; rs=addr -> rs_pending=1 during the stall.
REQ-036 Assert reset the cycle after a grant to addr 9 -> wb_we=0 immediately, r9 not written, next grant starts at index 0.
REQ-037 Slots 0 and 3 both write r31 with 0xA and 0xB -> r31 final value 0xB; rt=31 gives rt_pending=1 until the second write retires.
